pipe_stage_regs: RTL
====================

Name: pipe_stage_regs

Overview:
- Fetch/decode/execute pipeline register bank for the pipelined MIPS core.
- Consumes the hazard unit's StallF, StallD and FlushE, plus the branch-taken PCSrcD.
- Holds PC_F, the IF/ID register and the ID/EX register, inserting bubbles and holds exactly as commanded.
- Also keeps stall/flush performance counters and a sticky hazard-consistency error flag.

Parameters:
- W, 32, datapath and instruction width.
- CW, 10, width of the decoded control bundle carried from D to E.
- RESET_PC, 32'h0000_0000, PC value after reset.
- CNT_W, 16, width of the saturating performance counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- StallF  in  1  hold PC_F.
- StallD  in  1  hold the IF/ID register.
- FlushE  in  1  load a bubble into the ID/EX register.
- PCSrcD  in  1  branch taken in D: redirect PC and flush IF/ID.
- PCBranch_D  in  W  branch target.
- Instr_F  in  W  instruction-memory read data at PC_F.
- Ctrl_D  in  CW  decoded control bundle.
- RD1_D, RD2_D  in  W each  register-file read data.
- SignImm_D  in  W  sign-extended immediate.
- RS_D_in, RT_D_in, RD_D_in  in  5 each  register specifiers from decode.
- PC_F  out  W  fetch PC.
- Instr_D  out  W  IF/ID instruction.
- PCPlus4_D  out  W  IF/ID PC+4.
- valid_D  out  1  IF/ID holds a real instruction.
- Ctrl_E  out  CW  execute-stage control bundle.
- RD1_E, RD2_E, SignImm_E  out  W each  execute-stage operands.
- RS_E, RT_E, RD_E  out  5 each  execute-stage register specifiers.
- valid_E  out  1  ID/EX holds a real instruction.
- stall_cnt  out  CNT_W  count of cycles with StallF asserted.
- flush_cnt  out  CNT_W  count of bubbles inserted.
- hazard_err  out  1  sticky: StallF != StallD was seen.

Behaviour:
- Reset (async, rst_n=0):
  - PC_F = RESET_PC.
  - All IF/ID and ID/EX outputs = 0; valid_D = valid_E = 0.
  - Counters = 0; hazard_err = 0.
  - Applies immediately, including mid-stall or mid-flush; no pending state survives reset.
- PC register:
  - StallF=1: PC_F holds.
  - Otherwise PC_F <= PCSrcD ? PCBranch_D : PC_F+4.
  - The +4 is modulo 2^W; 32'hFFFF_FFFC wraps to 0.
- IF/ID register, priority StallD > PCSrcD > load:
  - StallD=1: hold all fields, including valid_D. A branch is not resolved while its operands are stalled, so PCSrcD is ignored for this register.
  - Else if PCSrcD=1: Instr_D=0 (NOP), PCPlus4_D=0, valid_D=0.
  - Else: Instr_D<=Instr_F, PCPlus4_D<=PC_F+4, valid_D<=1.
- ID/EX register (never stalls):
  - FlushE=1: Ctrl_E, RD1_E, RD2_E, SignImm_E, RS_E, RT_E, RD_E all 0; valid_E=0.
  - Otherwise capture the *_D inputs, RS_D_in/RT_D_in/RD_D_in, and valid_E<=valid_D.
  - Simultaneous FlushE and StallD (load-use or branch stall): D holds and E gets a bubble. This is the normal stall pattern.
- Latency: one cycle per stage. Instr_F at PC_F reaches Instr_D one edge later and Ctrl_E two edges later, absent stalls.
- Counters:
  - stall_cnt += 1 on each edge with StallF=1.
  - flush_cnt += 1 on each edge with FlushE=1, plus 1 more if (PCSrcD & !StallD) on the same edge; up to +2 per edge.
  - Both saturate at 2^CNT_W-1 with no wrap, including when a +2 would overshoot.
- hazard_err is set on any edge where StallF != StallD, and cleared only by reset.
- All outputs are registered; no combinational path from any input to any output.

Test Plan:
1. Reset then free-run 3 cycles with no stalls -> PC_F goes 0→4→8→C; Instr_D tracks Instr_F one cycle late; valid_D=1 from the first edge; valid_E=1 one edge later.
2. Load-use stall: StallF=StallD=FlushE=1 for 1 cycle at PC_F=0x10 -> PC_F and Instr_D hold; ID/EX all-zero with valid_E=0; stall_cnt=1, flush_cnt=1; flow resumes at 0x14.
3. Branch taken: PCSrcD=1, PCBranch_D=0x100, no stall -> next PC_F=0x100; Instr_D=0, valid_D=0; flush_cnt+1; the following cycle loads Instr_F from 0x100.
4. PCSrcD=1 together with StallD=StallF=1 -> PC_F and IF/ID hold (no redirect, no flush); the E bubble is still inserted if FlushE=1.
5. Preload a counter to 2^CNT_W-2 via forcing, then apply FlushE with PCSrcD (two increments on one edge) -> flush_cnt=2^CNT_W-1 and stays there.
6. Assert StallF without StallD for one cycle -> hazard_err=1 and it stays 1; then drop rst_n mid-stall -> all outputs return to reset values asynchronously, PC_F=RESET_PC.

Source files
------------

// File: rtl/pipe_stage_regs.sv
// Fetch PC, IF/ID and ID/EX pipeline registers for the pipelined MIPS core.
// The hazard unit drives the stall and flush inputs. The block also keeps stall/flush counters and a sticky error flag.
module pipe_stage_regs #(
    parameter int             W        = 32,
    parameter int             CW       = 10,
    parameter logic [W-1:0]   RESET_PC = '0,
    parameter int             CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             StallF,
    input  logic             StallD,
    input  logic             FlushE,
    input  logic             PCSrcD,
    input  logic [W-1:0]     PCBranch_D,
    input  logic [W-1:0]     Instr_F,
    input  logic [CW-1:0]    Ctrl_D,
    input  logic [W-1:0]     RD1_D,
    input  logic [W-1:0]     RD2_D,
    input  logic [W-1:0]     SignImm_D,
    input  logic [4:0]       RS_D_in,
    input  logic [4:0]       RT_D_in,
    input  logic [4:0]       RD_D_in,
    output logic [W-1:0]     PC_F,
    output logic [W-1:0]     Instr_D,
    output logic [W-1:0]     PCPlus4_D,
    output logic             valid_D,
    output logic [CW-1:0]    Ctrl_E,
    output logic [W-1:0]     RD1_E,
    output logic [W-1:0]     RD2_E,
    output logic [W-1:0]     SignImm_E,
    output logic [4:0]       RS_E,
    output logic [4:0]       RT_E,
    output logic [4:0]       RD_E,
    output logic             valid_E,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             hazard_err
);

    typedef struct packed {
        logic [CW-1:0] ctrl;
        logic [W-1:0]  rd1;
        logic [W-1:0]  rd2;
        logic [W-1:0]  imm;
        logic [4:0]    rs;
        logic [4:0]    rt;
        logic [4:0]    rd;
    } idExT;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [W-1:0]   pcPlus4;
    logic [2:1]     vldPipe;
    idExT           idEx;
    idExT           idExIn;
    logic [1:0]     flushInc;
    logic [CNT_W:0] flushSum;
    logic [CNT_W-1:0] flushNext;
    logic [CNT_W-1:0] stallNext;

    // Wraps naturally at 2^W.
    assign pcPlus4 = PC_F + {{(W-3){1'b0}}, 3'd4};

    assign idExIn = '{ctrl: Ctrl_D, rd1: RD1_D, rd2: RD2_D, imm: SignImm_D,
                      rs: RS_D_in, rt: RT_D_in, rd: RD_D_in};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            PC_F <= RESET_PC;
        else if (!StallF)
            PC_F <= PCSrcD ? PCBranch_D : pcPlus4;
    end

    // A stalled branch is not resolved, so StallD outranks the redirect flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Instr_D    <= '0;
            PCPlus4_D  <= '0;
            vldPipe[1] <= 1'b0;
        end else if (!StallD) begin
            if (PCSrcD) begin
                Instr_D    <= '0;
                PCPlus4_D  <= '0;
                vldPipe[1] <= 1'b0;
            end else begin
                Instr_D    <= Instr_F;
                PCPlus4_D  <= pcPlus4;
                vldPipe[1] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idEx       <= '0;
            vldPipe[2] <= 1'b0;
        end else if (FlushE) begin
            idEx       <= '0;
            vldPipe[2] <= 1'b0;
        end else begin
            idEx       <= idExIn;
            vldPipe[2] <= vldPipe[1];
        end
    end

    assign valid_D   = vldPipe[1];
    assign valid_E   = vldPipe[2];
    assign Ctrl_E    = idEx.ctrl;
    assign RD1_E     = idEx.rd1;
    assign RD2_E     = idEx.rd2;
    assign SignImm_E = idEx.imm;
    assign RS_E      = idEx.rs;
    assign RT_E      = idEx.rt;
    assign RD_E      = idEx.rd;

    // A bubble goes into E and another into D on a single edge. Clamp the sum so a +2 cannot wrap.
    assign flushInc  = {1'b0, FlushE} + {1'b0, PCSrcD & ~StallD};
    assign flushSum  = {1'b0, flush_cnt} + {{(CNT_W-1){1'b0}}, flushInc};
    assign flushNext = (flushSum > {1'b0, CNT_MAX}) ? CNT_MAX : flushSum[CNT_W-1:0];
    assign stallNext = (StallF && stall_cnt != CNT_MAX) ? stall_cnt + 1'b1 : stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt  <= '0;
            flush_cnt  <= '0;
            hazard_err <= 1'b0;
        end else begin
            stall_cnt  <= stallNext;
            flush_cnt  <= flushNext;
            if (StallF != StallD)
                hazard_err <= 1'b1;
        end
    end

endmodule
